// File: rtl/uart_init_seq.sv
// uart_init_seq: boot-time programmer for a 16550 UART APB slave, then transparent APB gatekeeper.
// Latency: each script write is 2 PCLK cycles plus UART wait states; pass-through adds 0 cycles.
// Backpressure: M_PREADY=0 freezes the script drive; CPU transfers wait (S_PREADY=0) until PASS.
//
// Optional feature macro: UART_INIT_VERIFY_EN adds an LCR readback after the script and the
// sticky InitErr output.
//
// Ports:
//   PCLK, PRESETn              clock, asynchronous active-low reset
//   S_P*                       CPU-side APB completer interface (from the uncore bridge)
//   M_P*                       UART-side APB requester interface (to the UART slave)
//   Reinit                     one-cycle request to rerun the script (honoured only in PASS)
//   InitDone                   high while the CPU owns the UART port
//   InitErr                    sticky LCR readback mismatch (only with UART_INIT_VERIFY_EN)
module uart_init_seq #(
  parameter int          XLEN    = 64,
  parameter logic [15:0] DIVISOR = 16'd1,
  parameter logic [7:0]  LCR_VAL = 8'h03,
  parameter logic [7:0]  FCR_VAL = 8'h07,
  parameter logic [7:0]  IER_VAL = 8'h00
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                S_PSEL,
  input  logic                S_PENABLE,
  input  logic                S_PWRITE,
  input  logic [2:0]          S_PADDR,
  input  logic [XLEN-1:0]     S_PWDATA,
  input  logic [XLEN/8-1:0]   S_PSTRB,
  output logic [XLEN-1:0]     S_PRDATA,
  output logic                S_PREADY,
  output logic                M_PSEL,
  output logic                M_PENABLE,
  output logic                M_PWRITE,
  output logic [2:0]          M_PADDR,
  output logic [XLEN-1:0]     M_PWDATA,
  output logic [XLEN/8-1:0]   M_PSTRB,
  input  logic [XLEN-1:0]     M_PRDATA,
  input  logic                M_PREADY,
  input  logic                Reinit,
  output logic                InitDone
`ifdef UART_INIT_VERIFY_EN
  ,
  output logic                InitErr
`endif
);

  localparam int NB = XLEN / 8;
  localparam int LW = $clog2(NB);

  typedef enum logic [2:0] {
    ST_SETUP   = 3'd0,
    ST_ACCESS  = 3'd1,
    ST_VSETUP  = 3'd2,
    ST_VACCESS = 3'd3,
    ST_PASS    = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic        pend_q, pend_d;

  logic [2:0]    scr_addr;
  logic [7:0]    scr_byte;
  logic [NB-1:0] scr_strb;

`ifdef UART_INIT_VERIFY_EN
  // Byte lane that carries LCR (address 3) on the data bus.
  localparam int LCR_LANE = 3 % NB;
  logic err_q, err_d;
`endif

  // Script table: step -> register address and data byte.
  always_comb begin
    scr_addr = 3'd3;
    scr_byte = 8'h80;
    case (step_q)
      3'd0: begin scr_addr = 3'd3; scr_byte = 8'h80;          end
      3'd1: begin scr_addr = 3'd0; scr_byte = DIVISOR[7:0];   end
      3'd2: begin scr_addr = 3'd1; scr_byte = DIVISOR[15:8];  end
      3'd3: begin scr_addr = 3'd3; scr_byte = LCR_VAL;        end
      3'd4: begin scr_addr = 3'd2; scr_byte = FCR_VAL;        end
      3'd5: begin scr_addr = 3'd1; scr_byte = IER_VAL;        end
      default: begin scr_addr = 3'd3; scr_byte = 8'h80;       end
    endcase
  end

  // Only the byte lane addressed by PADDR is strobed; data is replicated on every lane.
  assign scr_strb = {{(NB-1){1'b0}}, 1'b1} << scr_addr[LW-1:0];

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    pend_d    = pend_q;
`ifdef UART_INIT_VERIFY_EN
    err_d     = err_q;
`endif
    M_PSEL    = 1'b0;
    M_PENABLE = 1'b0;
    M_PWRITE  = 1'b0;
    M_PADDR   = 3'd0;
    M_PWDATA  = '0;
    M_PSTRB   = '0;
    S_PRDATA  = '0;
    S_PREADY  = 1'b0;

    case (state_q)
      ST_SETUP: begin
        M_PSEL   = 1'b1;
        M_PWRITE = 1'b1;
        M_PADDR  = scr_addr;
        M_PWDATA = {NB{scr_byte}};
        M_PSTRB  = scr_strb;
        state_d  = ST_ACCESS;
      end

      ST_ACCESS: begin
        M_PSEL    = 1'b1;
        M_PENABLE = 1'b1;
        M_PWRITE  = 1'b1;
        M_PADDR   = scr_addr;
        M_PWDATA  = {NB{scr_byte}};
        M_PSTRB   = scr_strb;
        if (M_PREADY) begin
          if (step_q == 3'd5) begin
            step_d  = 3'd0;
`ifdef UART_INIT_VERIFY_EN
            state_d = ST_VSETUP;
`else
            state_d = ST_PASS;
`endif
          end else begin
            step_d  = step_q + 3'd1;
            state_d = ST_SETUP;
          end
        end
      end

`ifdef UART_INIT_VERIFY_EN
      ST_VSETUP: begin
        M_PSEL  = 1'b1;
        M_PADDR = 3'd3;
        state_d = ST_VACCESS;
      end

      ST_VACCESS: begin
        M_PSEL    = 1'b1;
        M_PENABLE = 1'b1;
        M_PADDR   = 3'd3;
        if (M_PREADY) begin
          // A failed readback is reported but does not block handover to the CPU.
          if (M_PRDATA[8*LCR_LANE +: 8] != LCR_VAL) begin
            err_d = 1'b1;
          end
          state_d = ST_PASS;
        end
      end
`endif

      ST_PASS: begin
        M_PSEL    = S_PSEL;
        M_PENABLE = S_PENABLE;
        M_PWRITE  = S_PWRITE;
        M_PADDR   = S_PADDR;
        M_PWDATA  = S_PWDATA;
        M_PSTRB   = S_PSTRB;
        S_PRDATA  = M_PRDATA;
        S_PREADY  = M_PREADY;
        // A rerun request waits for a cycle with no CPU transfer selected so an
        // in-flight transfer is never cut off.
        if ((Reinit || pend_q) && !S_PSEL) begin
          state_d = ST_SETUP;
          step_d  = 3'd0;
          pend_d  = 1'b0;
        end else if (Reinit) begin
          pend_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_SETUP;
        step_d  = 3'd0;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_SETUP;
      step_q  <= 3'd0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      pend_q  <= pend_d;
    end
  end

`ifdef UART_INIT_VERIFY_EN
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign InitErr = err_q;
`endif

  assign InitDone = (state_q == ST_PASS);

endmodule
